// File: rtl/sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sweep_ctrl                                                      |
// | Purpose  : Sequences a DAC -> settle -> ADC -> UART voltage sweep over a   |
// |            downstream step counter. Optional macro SWEEP_LOOP_EN enables   |
// |            continuous sweeping while start_i stays high.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sweep_ctrl #(
  parameter int WIDTH         = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_COUNT     = 2**WIDTH - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             dac_done_i,
  input  logic             adc_done_i,
  input  logic             tx_done_i,
  output logic [1:0]       opc1_o,
  output logic             dac_start_o,
  output logic             adc_start_o,
  output logic             tx_start_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0]       c_opc_clear   = 2'b00;
  localparam logic [1:0]       c_opc_hold    = 2'b01;
  localparam logic [1:0]       c_opc_inc     = 2'b10;
  localparam logic [WIDTH-1:0] c_max_count   = WIDTH'(MAX_COUNT);
  localparam logic             c_skip_settle = (SETTLE_CYCLES == 0);
  // Loaded on entry to SETTLE; the state is left once the counter reads zero.
  localparam logic [7:0]       c_settle_load = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CLR    = 4'd1,
    ST_DAC    = 4'd2,
    ST_WDAC   = 4'd3,
    ST_SETTLE = 4'd4,
    ST_ADC    = 4'd5,
    ST_WADC   = 4'd6,
    ST_TX     = 4'd7,
    ST_WTX    = 4'd8,
    ST_CHK    = 4'd9,
    ST_INC    = 4'd10,
    ST_DONE   = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_settle_cnt;

  logic [1:0] w_opc;
  logic       w_dac_start;
  logic       w_adc_start;
  logic       w_tx_start;
  logic       w_busy;
  logic       w_done;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_settle_cnt <= 8'd0;
    end else if (r_state == ST_WDAC && dac_done_i) begin
      r_settle_cnt <= c_settle_load;
    end else if (r_state == ST_SETTLE && r_settle_cnt != 8'd0) begin
      r_settle_cnt <= r_settle_cnt - 8'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_state_next = ST_CLR;
      ST_CLR:    w_state_next = ST_DAC;
      ST_DAC:    w_state_next = ST_WDAC;
      ST_WDAC: begin
        if (dac_done_i) begin
          w_state_next = c_skip_settle ? ST_ADC : ST_SETTLE;
        end
      end
      ST_SETTLE: if (r_settle_cnt == 8'd0) w_state_next = ST_ADC;
      ST_ADC:    w_state_next = ST_WADC;
      ST_WADC:   if (adc_done_i) w_state_next = ST_TX;
      ST_TX:     w_state_next = ST_WTX;
      ST_WTX:    if (tx_done_i) w_state_next = ST_CHK;
      ST_CHK: begin
        if (count_i == c_max_count) begin
`ifdef SWEEP_LOOP_EN
          w_state_next = start_i ? ST_CLR : ST_DONE;
`else
          w_state_next = ST_DONE;
`endif
        end else begin
          w_state_next = ST_INC;
        end
      end
      ST_INC:    w_state_next = ST_DAC;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pulse is
  // glitch-free yet still lines up with the cycle its state is occupied.
  always_comb begin
    w_opc       = c_opc_hold;
    w_dac_start = 1'b0;
    w_adc_start = 1'b0;
    w_tx_start  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (w_state_next)
      ST_IDLE: w_busy      = 1'b0;
      ST_CLR:  w_opc       = c_opc_clear;
      ST_DAC:  w_dac_start = 1'b1;
      ST_ADC:  w_adc_start = 1'b1;
      ST_TX:   w_tx_start  = 1'b1;
      ST_INC:  w_opc       = c_opc_inc;
      ST_DONE: w_done      = 1'b1;
      default: w_opc       = c_opc_hold;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      opc1_o      <= c_opc_hold;
      dac_start_o <= 1'b0;
      adc_start_o <= 1'b0;
      tx_start_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      opc1_o      <= w_opc;
      dac_start_o <= w_dac_start;
      adc_start_o <= w_adc_start;
      tx_start_o  <= w_tx_start;
      busy_o      <= w_busy;
      done_o      <= w_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
`default_nettype none
// Scoreboarded bench for sweep_ctrl: a timestamped event model of the sweep
// protocol predicts every command/pulse; a monitor pops and compares them.
module tb_sweep_ctrl;

  localparam int WIDTH  = 2;
  localparam int MAXC   = 3;
  localparam int SETTLE = 2;
`ifdef SWEEP_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] count_i = '0;
  logic             dac_done_i = 1'b0, adc_done_i = 1'b0, tx_done_i = 1'b0;
  logic [1:0]       opc1_o;
  logic             dac_start_o, adc_start_o, tx_start_o, busy_o, done_o;

  logic             start0 = 1'b0, dac_done0 = 1'b0, adc_done0 = 1'b0, tx_done0 = 1'b0;
  logic [WIDTH-1:0] count0 = '0;
  logic [1:0]       opc0;
  logic             dac_start0, adc_start0, tx_start0, busy0, done0;

  sweep_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .MAX_COUNT(MAXC)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .count_i(count_i),
    .dac_done_i(dac_done_i), .adc_done_i(adc_done_i), .tx_done_i(tx_done_i),
    .opc1_o(opc1_o), .dac_start_o(dac_start_o), .adc_start_o(adc_start_o),
    .tx_start_o(tx_start_o), .busy_o(busy_o), .done_o(done_o)
  );

  sweep_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(0), .MAX_COUNT(MAXC)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start0), .count_i(count0),
    .dac_done_i(dac_done0), .adc_done_i(adc_done0), .tx_done_i(tx_done0),
    .opc1_o(opc0), .dac_start_o(dac_start0), .adc_start_o(adc_start0),
    .tx_start_o(tx_start0), .busy_o(busy0), .done_o(done0)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Downstream step counter driven by the controller's command.
  always @(posedge clk_i) begin
    if (opc1_o == 2'b00) count_i <= '0;
    else if (opc1_o == 2'b10) count_i <= count_i + 1'b1;
  end

  typedef enum int {EV_CLR, EV_DAC, EV_ADC, EV_TX, EV_INC, EV_DONE, EV_BAD} ev_e;
  typedef struct { ev_e kind; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(ev_e k, int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic observe(ev_e k);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: seen at cycle %0d, nothing expected", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 k.name(), cyc, e.kind.name(), e.cyc);
      end
    end
    if (k == EV_CLR || k == EV_DONE) check("busy_in_sweep", busy_o, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed_%s: expected at cycle %0d, absent by cycle %0d", e.kind.name(), e.cyc, cyc);
        end
        if (opc1_o == 2'b00) observe(EV_CLR);
        if (opc1_o == 2'b10) observe(EV_INC);
        if (opc1_o == 2'b11) observe(EV_BAD);
        if (dac_start_o)     observe(EV_DAC);
        if (adc_start_o)     observe(EV_ADC);
        if (tx_start_o)      observe(EV_TX);
        if (done_o)          observe(EV_DONE);
      end
    end
  end

  // Environment + reference model state
  int  n = 0, hold_left = 0, steps = 0, idle_from = 0;
  int  due_dac = -1, due_adc = -1, due_tx = -1, chk_at = -1, rst_at = -1, rst_chk = -1;
  bit  sweeping = 1'b0, kill = 1'b0, started = 1'b0, rst_force = 1'b1;

  task automatic tick();
    @(negedge clk_i);
    n = cyc;
    dac_done_i = 1'b0;
    adc_done_i = 1'b0;
    tx_done_i  = 1'b0;
    start_i = (hold_left > 0);
    if (hold_left > 0) hold_left--;
    rst_i = !(rst_force || n == rst_at);
    if (n == rst_chk) begin
      check("post_reset_busy", busy_o, 0);
      check("post_reset_opc", opc1_o, 1);
      check("post_reset_tx", tx_start_o, 0);
      rst_chk = -1;
    end
    if (!rst_i) begin
      sweeping = 1'b0;
      idle_from = n + 1;
      chk_at = -1; due_dac = -1; due_adc = -1; due_tx = -1;
      if (n == rst_at) rst_chk = n + 1;
      return;
    end
    // Stage responders; a done pulse in the start cycle itself must be ignored.
    if (dac_start_o) begin
      due_dac = n + $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) dac_done_i = 1'b1;
    end
    if (adc_start_o) begin
      if (kill) begin
        rst_at = n + 1;
        kill = 1'b0;
      end else begin
        due_adc = n + $urandom_range(1, 5);
        if ($urandom_range(0, 3) == 0) adc_done_i = 1'b1;
      end
    end
    if (tx_start_o) begin
      due_tx = n + $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) tx_done_i = 1'b1;
    end
    if (due_dac == n) begin dac_done_i = 1'b1; due_dac = -1; push(EV_ADC, n + SETTLE + 1); end
    if (due_adc == n) begin adc_done_i = 1'b1; due_adc = -1; push(EV_TX, n + 1); end
    if (due_tx == n)  begin tx_done_i = 1'b1;  due_tx = -1;  chk_at = n + 1; end
    if ($urandom_range(0, 2) == 0) begin
      if (due_dac > n && !dac_start_o) begin adc_done_i = 1'b1; tx_done_i = 1'($urandom_range(0, 1)); end
      if (due_adc > n && !adc_start_o) begin dac_done_i = 1'b1; tx_done_i = 1'($urandom_range(0, 1)); end
      if (due_tx > n && !tx_start_o)   begin dac_done_i = 1'b1; adc_done_i = 1'($urandom_range(0, 1)); end
    end
    // Reference model: the step decision uses the steps issued since the clear.
    if (n == chk_at) begin
      chk_at = -1;
      if (steps < MAXC) begin
        push(EV_INC, n + 1); push(EV_DAC, n + 2); steps++;
      end else if (LOOP && start_i) begin
        push(EV_CLR, n + 1); push(EV_DAC, n + 2); steps = 0;
      end else begin
        push(EV_DONE, n + 1); sweeping = 1'b0; idle_from = n + 2;
      end
    end
    if (!sweeping && n >= idle_from && start_i) begin
      push(EV_CLR, n + 1); push(EV_DAC, n + 2);
      steps = 0; sweeping = 1'b1; started = 1'b1;
    end
  endtask

  initial begin
    bit found;
    bit ok;
    tick(); tick();
    rst_force = 1'b0;
    tick();
    check("reset_opc", opc1_o, 1);
    check("reset_busy", busy_o, 0);
    check("reset_dac", dac_start_o, 0);
    check("reset_adc", adc_start_o, 0);
    check("reset_tx", tx_start_o, 0);
    check("reset_done", done_o, 0);
    mon_en = 1'b1;

    for (int t = 0; t < 8; t++) begin
      started = 1'b0;
      kill = (t == 3);
      if (t == 3 || t == 4) hold_left = 1;
      else if ($urandom_range(0, 2) == 0) hold_left = $urandom_range(30, 90);
      else hold_left = $urandom_range(1, 4);
      ok = 1'b0;
      for (int k = 0; k < 3000 && !ok; k++) begin
        tick();
        if (started && !sweeping && hold_left == 0 && n >= idle_from && exp_q.size() == 0) ok = 1'b1;
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL trial_%0d_timeout: sweep not finished in budget, pending=%0d", t, exp_q.size());
      end
      check("idle_busy", busy_o, 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Zero settle: ADC start must follow the DAC done by exactly one cycle.
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      if (dac_start0) found = 1'b1;
      else tick();
    end
    check("settle0_dac_seen", found, 1);
    tick();
    dac_done0 = 1'b1;
    tick();
    dac_done0 = 1'b0;
    check("settle0_adc_at_t1", adc_start0, 1);

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Width, 5: bit width of the voltage-step counter value.
REQ-002 SettleCycles, 16: number of wait cycles between DAC done and ADC start; range 0..255.
REQ-003 MaxCount, 2**Width-1: last step value of a sweep.
REQ-004 clk_i  in  1  sole clock; all logic is rising-edge.
REQ-005 rst_i  in  1  synchronous, active-low reset.
REQ-006 start_i  in  1  level request to run a sweep.
REQ-007 count_i  in  Width  current step value returned by the downstream counter.
REQ-008 dac_done_i, adc_done_i, tx_done_i  in  1 each  single-cycle completion pulses from the DAC, ADC and UART stages.
REQ-009 opc1_o  out  2  counter command: 00 = clear, 01 = hold, 10 = increment; 11 is never driven.
REQ-010 dac_start_o, adc_start_o, tx_start_o  out  1 each  single-cycle start pulses.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 done_o  out  1  single-cycle sweep-complete pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, CLR, DAC, WDAC, SETTLE, ADC, WADC, TX, WTX, CHK, INC and DONE, with Moore outputs only.
REQ-014 IDLE: opc1_o=01; go to CLR when start_i=1.
REQ-015 CLR: opc1_o=00 for exactly one cycle, then go to DAC.
REQ-016 DAC: dac_start_o=1 for one cycle, then go to WDAC; WDAC waits for dac_done_i.
REQ-017 SETTLE: count SettleCycles cycles with an 8-bit down-counter, then go to ADC; if SettleCycles=0, WDAC goes directly to ADC.
REQ-018 ADC: adc_start_o=1 for one cycle, then go to WADC; WADC waits for adc_done_i, then goes to TX.
REQ-019 TX: tx_start_o=1 for one cycle, then go to WTX; WTX waits for tx_done_i, then goes to CHK.
REQ-020 CHK: if count_i==MaxCount, go to DONE; otherwise go to INC.
REQ-021 INC: opc1_o=10 for exactly one cycle, then go to DAC.
REQ-022 DONE: done_o=1 for one cycle, then go to IDLE.
REQ-023 In every state other than CLR and INC, opc1_o SHALL be 01.
REQ-024 A done input pulse outside its matching wait state SHALL be ignored.
REQ-025 A done input arriving in the same cycle its start pulse is driven SHALL be ignored; only pulses seen in the wait state count.
REQ-026 Deasserting start_i mid-sweep SHALL NOT abort the sweep.
REQ-027 Latency from start_i sampled high in IDLE to dac_start_o high SHALL be 2 cycles.
REQ-028 No more than one start pulse SHALL be high in any cycle.

Reset
REQ-029 When rst_i=0 at a clock edge, the FSM SHALL enter IDLE and the settle counter SHALL clear to 0.
REQ-030 Reset values: opc1_o=01; all start pulses, busy_o and done_o = 0.
REQ-031 Reset asserted mid-sweep SHALL take effect at the next edge, with no pulse emitted that cycle.

Configuration
REQ-032 With SWEEP_LOOP_EN defined, CHK at count_i==MaxCount SHALL go to CLR while start_i=1 (continuous sweep, no done_o) and to DONE when start_i=0.
REQ-033 Without SWEEP_LOOP_EN, behaviour SHALL be exactly as in REQ-020 (single sweep).

Verification (Width=2, MaxCount=3, SettleCycles=2; done inputs return 3 cycles after each start)
REQ-034 Reset: rst_i=0 for 2 cycles -> opc1_o=01, busy_o=0, all pulses 0.
REQ-035 Single sweep: start_i pulse, counter model applied -> 4 each of dac_start_o, adc_start_o and tx_start_o; opc1_o=00 once, 10 three times; done_o once after the 4th tx_done_i.
REQ-036 Settle: dac_done_i at cycle t -> adc_start_o at t+3; with SettleCycles=0 -> adc_start_o at t+1.
REQ-037 Stray pulses: adc_done_i during WDAC -> no state change; sweep completes normally.
REQ-038 Mid-sweep reset: rst_i=0 during WADC -> IDLE next cycle, no tx_start_o; then start_i -> opc1_o=00 clear again.
REQ-039 SWEEP_LOOP_EN with start_i held -> second CLR follows count 3 with no done_o; drop start_i -> done_o after the current sweep.
